// File: rtl/alu_sequencer.sv
// Two-cycle FETCH/EXEC sequencer for the accumulator datapath: owns the PC and
// the condition-code register, decodes 9-bit instructions into ALU controls.
module alu_sequencer #(
    parameter int PC_W = 10
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    output logic [PC_W-1:0] pc,
    input  logic [8:0]      instr,
    output logic [3:0]      alu_op,
    output logic [4:0]      reg_addr,
    output logic            imm_sel,
    output logic [7:0]      imm,
    output logic            acc_we,
    output logic            reg_we,
    output logic            cc,
    input  logic            cc_alu,
    output logic            done,
    output logic            err
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_FETCH = 2'd1;
    localparam logic [1:0] S_EXEC  = 2'd2;
    localparam logic [1:0] S_HALT  = 2'd3;

    localparam logic [3:0] OP_PASS_VAL = 4'h0;
    localparam logic [3:0] OP_PASS_ACC = 4'h1;
    localparam logic [3:0] OP_MIN      = 4'h8;
    localparam logic [3:0] OP_LDI      = 4'h9;
    localparam logic [3:0] OP_BCC      = 4'hA;
    localparam logic [3:0] OP_JMP      = 4'hB;
    localparam logic [3:0] OP_HALT     = 4'hF;

    logic [1:0]      r_state;
    logic [PC_W-1:0] r_pc;
    logic            r_cc;
    logic            r_err;

    logic            w_exec;
    logic [3:0]      w_opc;
    logic [4:0]      w_fld;
    logic            w_alu_cls;
    logic            w_ldi;
    logic            w_illegal;
    logic            w_stop;
    logic            w_take;
    logic [PC_W-1:0] w_offs;
    logic [PC_W-1:0] w_pc_next;

    assign w_exec    = (r_state == S_EXEC);
    assign w_opc     = instr[8:5];
    assign w_fld     = instr[4:0];
    assign w_alu_cls = (w_opc <= OP_MIN);
    assign w_ldi     = (w_opc == OP_LDI);
    assign w_illegal = (w_opc > OP_JMP) && (w_opc != OP_HALT);
    assign w_stop    = w_illegal || (w_opc == OP_HALT);

    // Branch offset is a signed 5-bit field; the sum wraps modulo 2^PC_W.
    assign w_offs    = {{(PC_W-5){w_fld[4]}}, w_fld};
    assign w_take    = (w_opc == OP_JMP) || ((w_opc == OP_BCC) && r_cc);
    assign w_pc_next = w_take ? (r_pc + w_offs) : (r_pc + PC_W'(1));

    // Controls are purely combinational from state, so reset drops them at once.
    always_comb begin
        alu_op   = OP_PASS_ACC;
        reg_addr = 5'd0;
        imm      = 8'd0;
        imm_sel  = 1'b0;
        acc_we   = 1'b0;
        reg_we   = 1'b0;
        if (w_exec) begin
            reg_addr = w_fld;
            imm      = {3'b000, w_fld};
            if (w_alu_cls) begin
                alu_op = w_opc;
                acc_we = (w_opc != OP_PASS_ACC);
                reg_we = (w_opc == OP_PASS_ACC);
            end else if (w_ldi) begin
                alu_op  = OP_PASS_VAL;
                imm_sel = 1'b1;
                acc_we  = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_pc    <= '0;
            r_cc    <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE, S_HALT: begin
                    if (start) begin
                        r_state <= S_FETCH;
                        r_pc    <= '0;
                        r_err   <= 1'b0;
                    end
                end
                S_FETCH: r_state <= S_EXEC;
                S_EXEC: begin
                    if (w_alu_cls || w_ldi)
                        r_cc <= cc_alu;
                    if (w_stop) begin
                        r_state <= S_HALT;
                        r_err   <= r_err | w_illegal;
                    end else begin
                        r_state <= S_FETCH;
                        r_pc    <= w_pc_next;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign pc   = r_pc;
    assign cc   = r_cc;
    assign err  = r_err;
    assign done = (r_state == S_HALT);

endmodule

// File: tb/tb_alu_sequencer.sv
// Bench for alu_sequencer: directed programs plus random ROM images, checked
// instruction-by-instruction against an architectural model of the sequencer.
module tb_alu_sequencer;

    localparam int PC_W = 10;
    localparam int ROM_N = 1 << PC_W;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            start = 1'b0;
    logic            cc_alu = 1'b0;
    logic [8:0]      instr;
    logic [PC_W-1:0] pc;
    logic [3:0]      alu_op;
    logic [4:0]      reg_addr;
    logic            imm_sel;
    logic [7:0]      imm;
    logic            acc_we;
    logic            reg_we;
    logic            cc;
    logic            done;
    logic            err;

    logic [8:0] rom [0:ROM_N-1];

    int checks = 0;
    int errors = 0;
    int m_pc;
    bit m_cc;
    bit m_err;
    int cc_mode = 2;   // 0/1: force cc_alu, 2: random
    bit noise = 0;     // toggle start randomly while running
    bit halted;

    alu_sequencer #(.PC_W(PC_W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .pc(pc), .instr(instr),
        .alu_op(alu_op), .reg_addr(reg_addr), .imm_sel(imm_sel), .imm(imm),
        .acc_we(acc_we), .reg_we(reg_we), .cc(cc), .cc_alu(cc_alu),
        .done(done), .err(err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) instr <= rom[pc];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [8:0] mk(input logic [3:0] op, input logic [4:0] f);
        return {op, f};
    endfunction

    task automatic clear_rom();
        for (int a = 0; a < ROM_N; a++) rom[a] = mk(4'hF, 5'd0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        m_cc = 1'b0;
        m_err = 1'b0;
    endtask

    // Starts the program at address 0 and follows it one instruction at a time.
    task automatic run_prog(input int max_instr, output bit hlt);
        logic [8:0] ins;
        logic [3:0] op;
        logic [4:0] f;
        int off;
        bit ccb;
        start = 1'b1;
        tick();
        start = 1'b0;
        m_pc = 0;
        m_err = 1'b0;
        hlt = 1'b0;
        for (int n = 0; n < max_instr && !hlt; n++) begin
            chk("fetch_pc", pc, m_pc);
            chk("fetch_strobes", {acc_we, reg_we, imm_sel}, 0);
            chk("fetch_alu_op", alu_op, 1);
            chk("fetch_done", done, 0);
            chk("fetch_cc", cc, m_cc);
            chk("fetch_err", err, m_err);
            if (noise) start = 1'($urandom_range(0, 1));
            tick();
            ins = rom[m_pc];
            op = ins[8:5];
            f = ins[4:0];
            chk("exec_pc", pc, m_pc);
            chk("exec_acc_we", acc_we, ((op <= 8 && op != 1) || op == 9) ? 1 : 0);
            chk("exec_reg_we", reg_we, (op == 1) ? 1 : 0);
            chk("exec_imm_sel", imm_sel, (op == 9) ? 1 : 0);
            chk("exec_reg_addr", reg_addr, f);
            chk("exec_imm", imm, {3'b000, f});
            if (op <= 9) chk("exec_alu_op", alu_op, (op == 9) ? 0 : op);
            else chk("exec_alu_op_defined", (alu_op <= 8) ? 1 : 0, 1);
            chk("exec_done", done, 0);
            ccb = (cc_mode == 2) ? 1'($urandom_range(0, 1)) : 1'(cc_mode);
            cc_alu = ccb;
            off = f[4] ? int'(f) - 32 : int'(f);
            if (op <= 9) begin
                m_cc = ccb;
                m_pc = (m_pc + 1) & (ROM_N - 1);
            end else if (op == 4'hA) begin
                m_pc = (m_pc + (m_cc ? off : 1)) & (ROM_N - 1);
            end else if (op == 4'hB) begin
                m_pc = (m_pc + off) & (ROM_N - 1);
            end else begin
                hlt = 1'b1;
                if (op != 4'hF) m_err = 1'b1;
            end
            if (hlt || !noise) start = 1'b0;
            else start = 1'($urandom_range(0, 1));
            tick();
        end
        start = 1'b0;
        if (hlt) begin
            chk("halt_done", done, 1);
            chk("halt_err", err, m_err);
            chk("halt_pc", pc, m_pc);
            chk("halt_cc", cc, m_cc);
            chk("halt_strobes", {acc_we, reg_we, imm_sel}, 0);
            tick();
            chk("halt_done_held", done, 1);
            chk("halt_pc_held", pc, m_pc);
        end
    endtask

    initial begin
        clear_rom();
        m_cc = 1'b0;
        m_err = 1'b0;
        #2;
        chk("rst_pc", pc, 0);
        chk("rst_cc", cc, 0);
        chk("rst_strobes", {acc_we, reg_we, imm_sel}, 0);
        chk("rst_alu_op", alu_op, 1);
        chk("rst_reg_addr", reg_addr, 0);
        chk("rst_imm", imm, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        tick();
        rst_n = 1'b1;
        tick();
        chk("idle_done", done, 0);

        // LDI 5; ADD r3; HALT
        rom[0] = mk(4'h9, 5'd5);
        rom[1] = mk(4'h2, 5'd3);
        rom[2] = mk(4'hF, 5'd0);
        cc_mode = 2;
        run_prog(10, halted);
        chk("prog1_halted", halted, 1);
        chk("prog1_pc", pc, 2);

        // SUB then BCC -2 at pc 5, taken and not taken
        clear_rom();
        rom[0] = mk(4'hB, 5'd4);
        rom[4] = mk(4'h3, 5'd1);
        rom[5] = mk(4'hA, 5'h1E);
        cc_mode = 1;
        run_prog(10, halted);
        chk("bcc_taken_pc", pc, 3);
        cc_mode = 0;
        run_prog(10, halted);
        chk("bcc_not_taken_pc", pc, 6);

        // JMP -16 from pc 3 wraps to 1011
        clear_rom();
        rom[0] = mk(4'hB, 5'd3);
        rom[3] = mk(4'hB, 5'h10);
        run_prog(10, halted);
        chk("jmp_wrap_pc", pc, 1011);

        // Illegal opcode at pc 4
        clear_rom();
        rom[0] = mk(4'hB, 5'd4);
        rom[4] = mk(4'hD, 5'd7);
        cc_mode = 1;
        run_prog(10, halted);
        chk("illegal_err", err, 1);
        chk("illegal_cc_kept", cc, 0);

        // PASS_ACC r9 reloads cc; restart also clears err
        clear_rom();
        rom[0] = mk(4'h1, 5'd9);
        cc_mode = 1;
        run_prog(10, halted);
        chk("passacc_cc1", cc, 1);
        chk("passacc_err_cleared", err, 0);
        cc_mode = 0;
        run_prog(10, halted);
        chk("passacc_cc0", cc, 0);

        // Reset while an LDI strobe is high
        clear_rom();
        rom[0] = mk(4'h9, 5'd7);
        rom[1] = mk(4'h9, 5'd1);
        rom[2] = mk(4'h2, 5'd2);
        rom[3] = mk(4'h3, 5'd3);
        rom[4] = mk(4'h1, 5'd4);
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        chk("pre_rst_acc_we", acc_we, 1);
        rst_n = 1'b0;
        #1;
        chk("async_rst_acc_we", acc_we, 0);
        chk("async_rst_alu_op", alu_op, 1);
        chk("async_rst_done", done, 0);
        tick();
        rst_n = 1'b1;
        m_cc = 1'b0;
        chk("post_rst_cc", cc, 0);
        noise = 1;
        cc_mode = 2;
        run_prog(20, halted);
        chk("noise_halted", halted, 1);
        noise = 0;

        // Random ROM images
        for (int p = 0; p < 24; p++) begin
            for (int a = 0; a < ROM_N; a++) rom[a] = 9'($urandom);
            run_prog(60, halted);
            if (!halted) do_reset();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
